// File: rtl/bldc_six_step_pwm.sv
// Six-step BLDC commutation with a programmable PWM carrier, per-switch dead time,
// commutation-rate divider, direction control and a mid-on-time ADC sample strobe.
//
// step | meaning ({AH,AL,BH,BL,CH,CL} drive pattern)
// S0   | 100110
// S1   | 100101
// S2   | 101001
// S3   | 011001
// S4   | 011010
// S5   | 010110
module bldc_six_step_pwm #(
  parameter int CNT_W      = 16,
  parameter int DT_W       = 8,
  parameter int PERIOD_RST = 1599,
  parameter int DEAD_RST   = 32
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [31:0] MOT_ADDR,
  input  logic [31:0] MOT_DI,
  input  logic        MOT_WE,
  input  logic        MOT_RE,
  output logic [31:0] MOT_DO,
  output logic [5:0]  PWM_OUT,
  output logic        DRV_EN,
  output logic        CURR_SAMP
);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PERIOD   = 3'd1;
  localparam logic [2:0] A_DUTY     = 3'd2;
  localparam logic [2:0] A_DEAD     = 3'd3;
  localparam logic [2:0] A_STEP_DIV = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } step_e;

  logic [3:0]       r_ctrl;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  logic [DT_W-1:0]  r_dead;
  logic [CNT_W-1:0] r_step_div;

  logic [CNT_W-1:0] r_period_act;
  logic [CNT_W-1:0] r_duty_act;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pcnt;

  step_e            r_step;
  step_e            w_step_nxt;

  logic [DT_W-1:0]  r_dc [6];
  logic [5:0]       r_pwm_out;
  logic             r_drv_en;

  logic             w_run;
  logic             w_dir;
  logic             w_samp_en;
  logic             w_wrap;
  logic             w_adv;
  logic             w_pwm_on;
  logic [5:0]       w_tbl;
  logic [5:0]       w_req;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_run     = r_ctrl[0];
  assign w_dir     = r_ctrl[1];
  assign w_samp_en = r_ctrl[3];
  assign w_unused  = &{1'b0, MOT_ADDR[31:3], MOT_DI[31:CNT_W]};

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      r_ctrl     <= '0;
      r_period   <= CNT_W'(PERIOD_RST);
      r_duty     <= '0;
      r_dead     <= DT_W'(DEAD_RST);
      r_step_div <= '0;
    end else if (MOT_WE) begin
      case (MOT_ADDR[2:0])
        A_CTRL:     r_ctrl     <= MOT_DI[3:0];
        A_PERIOD:   r_period   <= MOT_DI[CNT_W-1:0];
        A_DUTY:     r_duty     <= MOT_DI[CNT_W-1:0];
        A_DEAD:     r_dead     <= MOT_DI[DT_W-1:0];
        A_STEP_DIV: r_step_div <= MOT_DI[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Shadows track the register file while stopped so a restart uses fresh values.
  assign w_wrap = w_run && (r_cnt == r_period_act);
  assign w_adv  = w_wrap && (r_pcnt >= r_step_div);

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      r_cnt        <= '0;
      r_pcnt       <= '0;
      r_period_act <= CNT_W'(PERIOD_RST);
      r_duty_act   <= '0;
    end else if (!w_run) begin
      r_cnt        <= '0;
      r_pcnt       <= '0;
      r_period_act <= r_period;
      r_duty_act   <= r_duty;
    end else if (w_wrap) begin
      r_cnt        <= '0;
      r_period_act <= r_period;
      r_duty_act   <= r_duty;
      r_pcnt       <= w_adv ? '0 : r_pcnt + 1'b1;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) r_step <= S0;
    else         r_step <= w_step_nxt;
  end

  always_comb begin
    w_step_nxt = r_step;
    w_tbl      = 6'b000000;
    case (r_step)
      S0: begin
        w_tbl = 6'b100110;
        if (w_adv) w_step_nxt = w_dir ? S5 : S1;
      end
      S1: begin
        w_tbl = 6'b100101;
        if (w_adv) w_step_nxt = w_dir ? S0 : S2;
      end
      S2: begin
        w_tbl = 6'b101001;
        if (w_adv) w_step_nxt = w_dir ? S1 : S3;
      end
      S3: begin
        w_tbl = 6'b011001;
        if (w_adv) w_step_nxt = w_dir ? S2 : S4;
      end
      S4: begin
        w_tbl = 6'b011010;
        if (w_adv) w_step_nxt = w_dir ? S3 : S5;
      end
      S5: begin
        w_tbl = 6'b010110;
        if (w_adv) w_step_nxt = w_dir ? S4 : S0;
      end
      default: w_step_nxt = S0;
    endcase
  end

  // High sides (bits 5,3,1) are chopped by the carrier; low sides follow the table.
  assign w_pwm_on = (r_cnt < r_duty_act);
  assign w_req    = w_run ? (w_tbl & (w_pwm_on ? 6'b111111 : 6'b010101)) : 6'b000000;

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      for (int i = 0; i < 6; i++) r_dc[i] <= '0;
      r_pwm_out <= '0;
      r_drv_en  <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (!w_req[i])              r_dc[i] <= '0;
        else if (r_dc[i] < r_dead)  r_dc[i] <= r_dc[i] + 1'b1;
        else                        r_dc[i] <= r_dead;
        r_pwm_out[i] <= w_req[i] && (r_dc[i] == r_dead);
      end
      r_drv_en <= r_ctrl[2];
    end
  end

  assign PWM_OUT   = r_pwm_out;
  assign DRV_EN    = r_drv_en;
  assign CURR_SAMP = w_run && w_samp_en && (r_duty_act != '0) && (r_cnt == (r_duty_act >> 1));

  always_comb begin
    w_rdata = '0;
    case (MOT_ADDR[2:0])
      A_CTRL:     w_rdata[3:0]       = r_ctrl;
      A_PERIOD:   w_rdata[CNT_W-1:0] = r_period;
      A_DUTY:     w_rdata[CNT_W-1:0] = r_duty;
      A_DEAD:     w_rdata[DT_W-1:0]  = r_dead;
      A_STEP_DIV: w_rdata[CNT_W-1:0] = r_step_div;
      A_STATUS: begin
        w_rdata[2:0]        = r_step;
        w_rdata[3]          = w_run;
        w_rdata[CNT_W+15:16] = r_pcnt;
      end
      default: ;
    endcase
  end

  assign MOT_DO = MOT_RE ? w_rdata : 32'h0;

endmodule

// File: tb/tb_bldc_six_step_pwm.sv
// Directed bench for bldc_six_step_pwm: table-driven PWM/step vectors plus
// hand-written sequences for shadow loading, sample strobe and run stop/resume.
module tb_bldc_six_step_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] di = 32'd0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] mot_do;
  logic [5:0]  pwm;
  logic        drv_en;
  logic        samp;

  int checks = 0;
  int failures = 0;
  int kk = 0;

  typedef struct {
    int         k;
    logic [5:0] pwm;
    logic [2:0] st;
  } vec_t;

  vec_t vt [33];

  bldc_six_step_pwm dut (
    .OPB_CLK  (clk),
    .OPB_RST  (rst),
    .MOT_ADDR (addr),
    .MOT_DI   (di),
    .MOT_WE   (we),
    .MOT_RE   (re),
    .MOT_DO   (mot_do),
    .PWM_OUT  (pwm),
    .DRV_EN   (drv_en),
    .CURR_SAMP(samp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=0x%0h required=0x%0h", name, kk, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    kk++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; di = d; we = 1'b1;
    kk++;
    @(negedge clk);
    we = 1'b0; addr = 32'd5;
    kk++;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; re = 1'b1;
    #1;
    chk(name, mot_do, exp);
    addr = 32'd5;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Ends at the sample point right after the CTRL write edge, which is k=0.
  task automatic cfg(input int per, input int duty, input int dead, input int sdiv, input int ctrl);
    wr(32'd1, 32'(per));
    wr(32'd2, 32'(duty));
    wr(32'd3, 32'(dead));
    wr(32'd4, 32'(sdiv));
    addr = 32'd5; re = 1'b1;
    wr(32'd0, 32'(ctrl));
    kk = 0;
  endtask

  task automatic run_tbl(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      while (kk < vt[i].k) tick();
      chk({tag, "_pwm"}, 32'(pwm), 32'(vt[i].pwm));
      chk({tag, "_step"}, 32'(mot_do[2:0]), 32'(vt[i].st));
    end
  endtask

  initial begin
    logic [5:0] hi_acc;
    int         samp_cnt;

    // forward, DUTY=5 DEAD=0: PWM at sample k shows cnt=(k-1)%10 of period (k-1)/10
    vt[0]  = '{2,  6'b100110, 3'd0};
    vt[1]  = '{5,  6'b100110, 3'd0};
    vt[2]  = '{6,  6'b000100, 3'd0};
    vt[3]  = '{7,  6'b000100, 3'd0};
    vt[4]  = '{12, 6'b100101, 3'd1};
    vt[5]  = '{17, 6'b000101, 3'd1};
    vt[6]  = '{22, 6'b101001, 3'd2};
    vt[7]  = '{27, 6'b000001, 3'd2};
    vt[8]  = '{32, 6'b011001, 3'd3};
    vt[9]  = '{37, 6'b010001, 3'd3};
    vt[10] = '{42, 6'b011010, 3'd4};
    vt[11] = '{47, 6'b010000, 3'd4};
    vt[12] = '{52, 6'b010110, 3'd5};
    vt[13] = '{57, 6'b010100, 3'd5};
    vt[14] = '{62, 6'b100110, 3'd0};
    vt[15] = '{67, 6'b000100, 3'd0};
    // reverse
    vt[16] = '{2,  6'b100110, 3'd0};
    vt[17] = '{12, 6'b010110, 3'd5};
    vt[18] = '{17, 6'b010100, 3'd5};
    vt[19] = '{22, 6'b011010, 3'd4};
    vt[20] = '{32, 6'b011001, 3'd3};
    vt[21] = '{42, 6'b101001, 3'd2};
    vt[22] = '{52, 6'b100101, 3'd1};
    vt[23] = '{62, 6'b100110, 3'd0};
    // DEAD=3, DUTY=5: rising edges delayed by 4 cycles, high pulses 2 wide
    vt[24] = '{3,  6'b000000, 3'd0};
    vt[25] = '{4,  6'b100110, 3'd0};
    vt[26] = '{5,  6'b100110, 3'd0};
    vt[27] = '{6,  6'b000100, 3'd0};
    vt[28] = '{10, 6'b000100, 3'd1};
    vt[29] = '{13, 6'b000100, 3'd1};
    vt[30] = '{14, 6'b100101, 3'd1};
    vt[31] = '{15, 6'b100101, 3'd1};
    vt[32] = '{16, 6'b000101, 3'd1};

    // reset, with a write held active to show reset wins
    rst = 1'b1; addr = 32'd1; di = 32'd5; we = 1'b1; re = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; we = 1'b0;
    #1;
    chk("rst_do_re0", mot_do, 32'd0);
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_drv_en", 32'(drv_en), 32'd0);
    chk("rst_samp", 32'(samp), 32'd0);
    rd_chk("rst_ctrl", 32'd0, 32'd0);
    rd_chk("rst_period", 32'd1, 32'd1599);
    rd_chk("rst_duty", 32'd2, 32'd0);
    rd_chk("rst_dead", 32'd3, 32'd32);
    rd_chk("rst_stepdiv", 32'd4, 32'd0);
    rd_chk("rst_status", 32'd5, 32'd0);
    rd_chk("rst_addr6", 32'd6, 32'd0);
    rd_chk("rst_addr7", 32'd7, 32'd0);
    wr(32'd6, 32'hFFFF);
    rd_chk("unlisted_wr", 32'd6, 32'd0);
    wr(32'h0000_0009, 32'd7);
    rd_chk("addr_alias", 32'd1, 32'd7);

    do_reset();
    cfg(9, 5, 0, 0, 1);
    run_tbl(0, 15, "fwd");

    do_reset();
    cfg(9, 5, 0, 0, 3);
    run_tbl(16, 23, "rev");

    do_reset();
    cfg(9, 5, 3, 0, 1);
    run_tbl(24, 32, "dead");

    // DUTY=3 with DEAD=3: high sides never pass the dead-time filter
    do_reset();
    cfg(9, 3, 3, 0, 1);
    hi_acc = 6'b0;
    while (kk < 40) begin
      tick();
      hi_acc |= pwm & 6'b101010;
      if (kk == 4)  chk("short_lo0", 32'(pwm), 32'h04);
      if (kk == 14) chk("short_lo1", 32'(pwm), 32'h05);
    end
    chk("short_hi_never", 32'(hi_acc), 32'd0);

    // DUTY written mid-period, then again exactly on the wrap edge
    do_reset();
    cfg(9, 5, 0, 0, 1);
    tick();
    wr(32'd2, 32'd8);
    while (kk < 5) tick();
    chk("mid_old_on", 32'(pwm), 32'h26);
    tick();
    chk("mid_old_off", 32'(pwm), 32'h04);
    while (kk < 18) tick();
    chk("mid_new_on", 32'(pwm), 32'h25);
    wr(32'd2, 32'd20);
    chk("mid_new_off", 32'(pwm), 32'h05);
    while (kk < 28) tick();
    chk("wrapwr_on", 32'(pwm), 32'h29);
    tick();
    chk("wrapwr_off", 32'(pwm), 32'h01);
    while (kk < 31) tick();
    chk("full_duty_c0", 32'(pwm), 32'h19);
    while (kk < 40) tick();
    chk("full_duty_c9", 32'(pwm), 32'h19);

    // sample strobe, driver enable, stop and resume
    do_reset();
    cfg(9, 8, 0, 0, 13);
    chk("drv_en_k0", 32'(drv_en), 32'd0);
    samp_cnt = 0;
    while (kk < 30) begin
      tick();
      if (samp) samp_cnt++;
      if (kk == 1) chk("drv_en_k1", 32'(drv_en), 32'd1);
      if (kk == 4) chk("samp_at_4", 32'(samp), 32'd1);
      if (kk == 5) chk("samp_at_5", 32'(samp), 32'd0);
    end
    chk("samp_count", 32'(samp_cnt), 32'd3);
    while (kk < 33) tick();
    wr(32'd0, 32'd12);
    chk("stop_pwm_lag", 32'(pwm), 32'h19);
    tick();
    chk("stop_pwm_off", 32'(pwm), 32'd0);
    chk("stop_status", mot_do, 32'h3);
    while (kk < 40) tick();
    chk("stop_hold_step", mot_do, 32'h3);
    chk("stop_hold_pwm", 32'(pwm), 32'd0);
    wr(32'd4, 32'd1);
    cfg(9, 8, 0, 1, 13);
    tick();
    chk("resume_k1", 32'(pwm), 32'h19);
    while (kk < 12) tick();
    chk("resume_pwm12", 32'(pwm), 32'h19);
    chk("resume_status12", mot_do, 32'h0001_000B);
    while (kk < 20) tick();
    chk("resume_pwm20", 32'(pwm), 32'h11);
    while (kk < 22) tick();
    chk("resume_pwm22", 32'(pwm), 32'h1A);
    chk("resume_status22", mot_do, 32'h0000_000C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
